// File: rtl/spi_adc_responder.sv
// SPI responder emulating a 12-bit serial ADC: serves {lead zeros, sample, tail}
// on miso and captures the master's mosi word, all from oversampled SPI pins.
module spi_adc_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 4,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic [DATA_W-1:0]     sample_in,
  output logic                  miso,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  frame_done,
  output logic                  short_frame
);

  localparam int TAIL  = FRAME_BITS - LEAD_ZEROS - DATA_W;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Handshake: none; cs frames a transfer, sck edges carry bits. Actions fire on
  // synchronized edges, SYNC_STAGES+1 clk cycles after the pin edge.

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sck_d;

  logic cs_s;
  logic sck_s;
  logic mosi_s;
  logic cs_rise;
  logic cs_fall;
  logic sck_rise;
  logic sck_fall;

  state_t                state;
  logic [CNT_W-1:0]      tx_cnt;
  logic [CNT_W-1:0]      rx_cnt;
  logic [FRAME_BITS-2:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_load;

  // Synchronizers reset to 0 so a cs held low through reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(cs);
      sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(sck);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign tx_load = FRAME_BITS'(sample_in) << TAIL;

  // The MSB goes straight to miso, so tx_shift only keeps the bits still to send.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      miso        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          busy <= 1'b0;
          if (cs_fall) begin
            state    <= ACTIVE;
            tx_shift <= tx_load[FRAME_BITS-2:0];
            miso     <= tx_load[FRAME_BITS-1];
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            busy     <= 1'b1;
          end
        end
        ACTIVE: begin
          // cs edges win; an sck edge in the same cycle is dropped.
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
            if (rx_cnt == CNT_W'(FRAME_BITS)) begin
              rx_data    <= rx_shift;
              frame_done <= 1'b1;
            end else begin
              short_frame <= 1'b1;
            end
          end else if (sck_rise) begin
            if (rx_cnt < CNT_W'(FRAME_BITS)) begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
              rx_cnt   <= rx_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (tx_cnt < CNT_W'(FRAME_BITS - 1)) begin
              miso     <= tx_shift[FRAME_BITS-2];
              tx_shift <= tx_shift << 1;
              tx_cnt   <= tx_cnt + 1'b1;
            end else begin
              miso <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: directed scenarios plus random frames, checked
// against a word-level model of what the master should see.
module tb_spi_adc_responder;

  localparam int FB = 16;
  localparam int LZ = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic          sck;
  logic          mosi;
  logic [DW-1:0] sample_in;
  logic          miso;
  logic          busy;
  logic [FB-1:0] rx_data;
  logic          frame_done;
  logic          short_frame;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .sck        (sck),
    .mosi       (mosi),
    .sample_in  (sample_in),
    .miso       (miso),
    .busy       (busy),
    .rx_data    (rx_data),
    .frame_done (frame_done),
    .short_frame(short_frame)
  );

  int pass_cnt   = 0;
  int fail_cnt   = 0;
  int total_cnt  = 0;
  int done_seen  = 0;
  int short_seen = 0;
  int busy_seen  = 0;
  int miso_seen  = 0;
  int half       = 5;

  logic [FB-1:0] exp_rx;
  logic [FB-1:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_done)  done_seen++;
    if (short_frame) short_seen++;
    if (busy)        busy_seen++;
    if (miso)        miso_seen++;
  end

  function automatic logic [FB-1:0] served(input logic [DW-1:0] s);
    int v;
    v = int'(s) * (2 ** (FB - LZ - DW));
    return v[FB-1:0];
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle(input logic bit_val);
    mosi = bit_val;
    wait_clks(half);
    sck = 1'b1;
    wait_clks(half);
    sck = 1'b0;
  endtask

  task automatic do_frame(input int nbits, input logic [FB-1:0] mosi_word,
                          input logic change_sample, input string tag);
    logic [FB-1:0] got;
    logic [FB-1:0] exp_word;
    logic [FB-1:0] mask;
    logic          extra_bad;
    int            d0;
    int            s0;
    got       = '0;
    extra_bad = 1'b0;
    exp_q.push_back(served(sample_in));
    d0 = done_seen;
    s0 = short_seen;
    check({tag, "_busy_before"}, 32'(busy), 32'd0);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (change_sample && i == 3) sample_in = DW'($urandom);
      mosi = (i < FB) ? mosi_word[FB-1-i] : 1'($urandom_range(0, 1));
      wait_clks(half);
      if (i < FB) got[FB-1-i] = miso;
      else        extra_bad = extra_bad | miso;
      if (i == 0) check({tag, "_busy_during"}, 32'(busy), 32'd1);
      sck = 1'b1;
      wait_clks(half);
      sck = 1'b0;
    end
    wait_clks(half);
    cs = 1'b1;
    wait_clks(half + 6);
    exp_word = exp_q.pop_front();
    mask = (nbits >= FB) ? '1 : ~({FB{1'b1}} >> nbits);
    check({tag, "_miso_word"}, 32'(got & mask), 32'(exp_word & mask));
    if (nbits > FB) check({tag, "_miso_extra"}, 32'(extra_bad), 32'd0);
    if (nbits >= FB) exp_rx = mosi_word;
    check({tag, "_done"}, 32'(done_seen - d0), (nbits >= FB) ? 32'd1 : 32'd0);
    check({tag, "_short"}, 32'(short_seen - s0), (nbits >= FB) ? 32'd0 : 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_miso_after"}, 32'(miso), 32'd0);
  endtask

  initial begin
    int d0;
    int s0;
    reset     = 1'b1;
    cs        = 1'b1;
    sck       = 1'b0;
    mosi      = 1'b0;
    sample_in = '0;
    exp_rx    = '0;
    wait_clks(5);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    reset = 1'b0;
    wait_clks(10);

    // Basic frame.
    sample_in = 12'hA5C;
    do_frame(16, 16'h1234, 1'b0, "basic");

    // Back-to-back.
    sample_in = 12'hFFF;
    do_frame(16, 16'h5A5A, 1'b0, "b2b_a");
    sample_in = 12'h001;
    do_frame(16, 16'h1234, 1'b0, "b2b_b");

    // Truncated frame keeps previous rx_data, then a full frame recovers.
    sample_in = 12'h3C3;
    do_frame(9, 16'hBEEF, 1'b0, "short");
    do_frame(16, 16'hC0DE, 1'b0, "after_short");

    // Over-long frame.
    sample_in = 12'h7E1;
    do_frame(20, 16'h8421, 1'b0, "long");

    // cs low across reset release: no response until a fresh high-then-low.
    cs    = 1'b0;
    reset = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    exp_rx = '0;
    wait_clks(4);
    busy_seen = 0;
    miso_seen = 0;
    d0 = done_seen;
    s0 = short_seen;
    for (int i = 0; i < 16; i++) sck_cycle(1'($urandom_range(0, 1)));
    wait_clks(8);
    check("cslow_busy", 32'(busy_seen), 32'd0);
    check("cslow_miso", 32'(miso_seen), 32'd0);
    check("cslow_pulses", 32'((done_seen - d0) + (short_seen - s0)), 32'd0);
    check("cslow_rx_data", 32'(rx_data), 32'd0);
    cs = 1'b1;
    wait_clks(10);
    sample_in = 12'h5A3;
    do_frame(16, 16'hF00D, 1'b0, "cslow_recover");

    // Reset after 6 sck cycles.
    d0 = done_seen;
    s0 = short_seen;
    cs = 1'b0;
    for (int i = 0; i < 6; i++) sck_cycle(1'($urandom_range(0, 1)));
    wait_clks(half);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    wait_clks(2);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    wait_clks(2);
    reset = 1'b0;
    exp_rx = '0;
    wait_clks(3);
    cs = 1'b1;
    wait_clks(10);
    check("midrst_pulses", 32'((done_seen - d0) + (short_seen - s0)), 32'd0);
    check("midrst_busy_post", 32'(busy), 32'd0);

    // sample_in changing mid-frame must not disturb the served word.
    sample_in = 12'h9B7;
    do_frame(16, 16'h0F0F, 1'b1, "sample_chg");

    // Random frames with random timing and lengths.
    for (int k = 0; k < 8; k++) begin
      half      = $urandom_range(4, 7);
      sample_in = DW'($urandom);
      do_frame($urandom_range(1, 20), FB'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- SPI responder (slave) that emulates the 12-bit serial ADC read by the team's SPI master state machine. It lets the master be exercised on-chip and in simulation without the external sensor.
- Serves a 16-bit frame on miso: 4 leading zeros, then 12 data bits MSB first.
- Captures the 16 bits the master shifts in on mosi and reports frame completion or truncation.
- All SPI inputs are asynchronous to clk. They are oversampled through synchronizers, and every action is taken on detected edges.

Parameters:
- FRAME_BITS, 16, number of SCK cycles in a complete frame
- LEAD_ZEROS, 4, zero bits driven before the data MSB
- DATA_W, 12, width of the sample word (LEAD_ZEROS + DATA_W <= FRAME_BITS; remaining tail bits are 0)
- SYNC_STAGES, 2, flip-flop stages on cs, sck and mosi

Ports:
- clk  input  1  system clock; sole clock domain
- reset  input  1  synchronous, active-high reset
- cs  input  1  chip select from master, active low, asynchronous
- sck  input  1  serial clock from master, idle low, asynchronous
- mosi  input  1  master-out data, asynchronous
- sample_in  input  DATA_W  value to be served; latched at frame start
- miso  output  1  serial data to master
- busy  output  1  high while a frame is in progress
- rx_data  output  FRAME_BITS  last complete word received on mosi, MSB first
- frame_done  output  1  one-cycle pulse: complete frame ended
- short_frame  output  1  one-cycle pulse: cs released before FRAME_BITS sck rising edges

Behaviour:
- Reset (synchronous, active-high; clock and reset named clk and reset):
  - Outputs: miso=0, busy=0, rx_data=0, frame_done=0, short_frame=0.
  - State goes to IDLE; counters cleared.
  - All synchronizer stages reset to 0, including cs. As a result, cs held low through reset produces no start; a frame begins only after cs has been seen high and then falls.
- Synchronization and edge detection:
  - Each of cs, sck and mosi passes through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one further flop.
  - Latency from pin edge to action is SYNC_STAGES+1 clk cycles.
  - Requirement on the master: sck high and low times are each >= 4 clk periods, and mosi is stable around the sck rising edge.
- States: IDLE, ACTIVE.
- IDLE:
  - miso=0, busy=0.
  - A cs falling edge moves to ACTIVE in the same cycle. In that cycle:
    - the shift register is loaded with {LEAD_ZEROS zeros, sample_in, zero tail};
    - miso takes the register MSB;
    - tx_cnt and rx_cnt are cleared;
    - busy goes to 1.
  - sck edges and cs rising edges in IDLE are ignored.
- ACTIVE, sck rising edge:
  - If rx_cnt < FRAME_BITS: the synchronized mosi is shifted into the rx shift register LSB, and rx_cnt increments.
  - Otherwise the edge is ignored; the counter saturates.
- ACTIVE, sck falling edge:
  - If tx_cnt < FRAME_BITS-1: the tx register shifts left, miso takes the new MSB, and tx_cnt increments.
  - After the last bit, miso=0 for any extra sck cycles.
- ACTIVE, cs rising edge: return to IDLE, busy=0, miso=0.
  - If rx_cnt == FRAME_BITS: rx_data is loaded from the rx shift register and frame_done pulses one cycle.
  - Otherwise rx_data is unchanged and short_frame pulses one cycle.
- Simultaneous events: a cs edge takes priority. Any sck edge detected in the same cycle as a cs edge is ignored.
- sample_in changes during a frame do not affect the frame in progress.
- Extra sck cycles beyond FRAME_BITS: no capture, miso=0, and the frame still counts as complete.
- Reset mid-frame: state aborts immediately to IDLE with no pulse. Because cs sync resets to 0, the responder waits for a fresh cs high-then-low sequence.

Test Plan:
1. reset, cs=1 for 10 cycles, sample_in=12'hA5C, 16-cycle mode-0 frame, mosi pattern 16'h1234 -> miso bits 0000_1010_0101_1100; frame_done pulse; rx_data=16'h1234; busy high only during frame.
2. Back-to-back frames, sample_in 12'hFFF then 12'h001 -> miso 16'h0FFF then 16'h0001; two frame_done pulses; rx_data updated each time.
3. cs released after 9 sck cycles, mosi=16'hBEEF prior word 16'h1234 -> short_frame pulse, no frame_done, rx_data stays 16'h1234; next full frame is correct.
4. 20 sck cycles in one frame -> bits 17-20 on miso are 0, rx_data equals the first 16 mosi bits, frame_done pulses.
5. cs held low across reset release, then sck toggled 16 times -> no response (miso=0, busy=0); after cs high then low, a normal frame is served.
6. Reset asserted after 6 sck cycles -> busy=0, miso=0, no pulses; sample_in changed mid-frame in a separate run -> served word is the value at the cs fall.
